// File: rtl/ama_riscv_hazard_fwd_unit_pkg.sv
// rtl/ama_riscv_hazard_fwd_unit_pkg.sv - shared constants, entry struct and width helpers
// Select encodings and tracked-entry layout used by the hazard/forwarding unit.
package ama_riscv_hazard_fwd_unit_pkg;

  localparam int RF_X0_ZERO        = 0;
  localparam int ALU_SEL_FWD_BASE  = 2;
  localparam int DMEM_DIN_FWD_BASE = 1;

  localparam int ENT_VALID_W = 1;
  localparam int ENT_WE_W    = 1;
  localparam int ENT_LOAD_W  = 1;

  // rd lives in a separate array because its width follows RF_ADDR_W
  typedef struct packed {
    logic [ENT_VALID_W-1:0] valid;
    logic [ENT_WE_W-1:0]    we;
    logic [ENT_LOAD_W-1:0]  load;
  } ent_flags_t;

  function automatic int fwd_sel_w(input int stages);
    return $clog2(stages + 2);
  endfunction

  function automatic int stage_idx_w(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/ama_riscv_hazard_fwd_unit_if.sv
// rtl/ama_riscv_hazard_fwd_unit_if.sv - decode-side bus of the hazard/forwarding unit
// master is the decode/pipeline side, slave is the hazard unit.
interface ama_riscv_hazard_fwd_unit_if
  import ama_riscv_hazard_fwd_unit_pkg::*;
#(
  parameter int RF_ADDR_W = 5,
  parameter int SEL_W     = fwd_sel_w(2)
);

  logic                 id_valid;
  logic [RF_ADDR_W-1:0] id_rs1;
  logic [RF_ADDR_W-1:0] id_rs2;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic [RF_ADDR_W-1:0] id_rd;
  logic                 id_reg_we;
  logic                 id_load;
  logic                 id_store;
  logic                 a_op_sel;
  logic                 b_op_sel;
  logic                 pipe_hold;
  logic                 id_flush;
  logic [SEL_W-1:0]     a_op_sel_fwd;
  logic [SEL_W-1:0]     b_op_sel_fwd;
  logic [SEL_W-1:0]     dmem_din_sel_fwd;
  logic                 stall_id;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_we, id_load, id_store, a_op_sel, b_op_sel, pipe_hold, id_flush,
    input  a_op_sel_fwd, b_op_sel_fwd, dmem_din_sel_fwd, stall_id
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_we, id_load, id_store, a_op_sel, b_op_sel, pipe_hold, id_flush,
    output a_op_sel_fwd, b_op_sel_fwd, dmem_din_sel_fwd, stall_id
  );

endinterface

// File: rtl/ama_riscv_fwd_match.sv
// rtl/ama_riscv_fwd_match.sv - per-source priority matcher over the tracked entries
// Reports whether a source hits a producer, the youngest hitting stage and whether it is a load.
module ama_riscv_fwd_match
  import ama_riscv_hazard_fwd_unit_pkg::*;
#(
  parameter int RF_ADDR_W  = 5,
  parameter int FWD_STAGES = 2,
  parameter int IDX_W      = stage_idx_w(FWD_STAGES)
) (
  input  logic                                  id_valid_i,
  input  logic [RF_ADDR_W-1:0]                  rs_i,
  input  logic                                  rs_used_i,
  input  ent_flags_t [FWD_STAGES-1:0]           ent_flags_i,
  input  logic [FWD_STAGES-1:0][RF_ADDR_W-1:0]  ent_rd_i,
  output logic                                  hit_o,
  output logic [IDX_W-1:0]                      stage_o,
  output logic                                  is_load_o
);

  logic src_live;

  assign src_live = id_valid_i && rs_used_i && (rs_i != RF_ADDR_W'(RF_X0_ZERO));

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    hit_o     = 1'b0;
    stage_o   = '0;
    is_load_o = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (src_live && ent_flags_i[k].valid[0] && ent_flags_i[k].we[0] &&
          (ent_rd_i[k] == rs_i)) begin
        hit_o     = 1'b1;
        stage_o   = IDX_W'(k);
        is_load_o = ent_flags_i[k].load[0];
      end
    end
  end

endmodule

// File: rtl/ama_riscv_hazard_fwd_unit.sv
// rtl/ama_riscv_hazard_fwd_unit.sv - forwarding select and load-use stall unit beside decode
// Optional stall counter port perf_stall_cnt when AMA_RISCV_HAZARD_PERF_EN is defined.
module ama_riscv_hazard_fwd_unit
  import ama_riscv_hazard_fwd_unit_pkg::*;
#(
  parameter int RF_ADDR_W  = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  ama_riscv_hazard_fwd_unit_if.slave     bus
`ifdef AMA_RISCV_HAZARD_PERF_EN
  ,
  output logic [31:0]                    perf_stall_cnt
`endif
);

  localparam int SEL_W = fwd_sel_w(FWD_STAGES);
  localparam int IDX_W = stage_idx_w(FWD_STAGES);

  if ((FWD_STAGES < 1) || (FWD_STAGES > 4)) begin : g_bad_stages
    $error("FWD_STAGES must be in 1..4");
  end
  if ((LOAD_LAT < 0) || (LOAD_LAT >= FWD_STAGES)) begin : g_bad_load_lat
    $error("LOAD_LAT must be in 0..FWD_STAGES-1");
  end

  ent_flags_t [FWD_STAGES-1:0]          flags_q, flags_d;
  logic [FWD_STAGES-1:0][RF_ADDR_W-1:0] rd_q, rd_d;

  logic             rs1_hit, rs2_hit;
  logic [IDX_W-1:0] rs1_stage, rs2_stage;
  logic             rs1_load, rs2_load;
  logic             rs1_load_use, rs2_load_use;
  logic             stall_id;
  logic             insert;

  ama_riscv_fwd_match #(
    .RF_ADDR_W  (RF_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .IDX_W      (IDX_W)
  ) u_match_rs1 (
    .id_valid_i  (bus.id_valid),
    .rs_i        (bus.id_rs1),
    .rs_used_i   (bus.id_rs1_used),
    .ent_flags_i (flags_q),
    .ent_rd_i    (rd_q),
    .hit_o       (rs1_hit),
    .stage_o     (rs1_stage),
    .is_load_o   (rs1_load)
  );

  ama_riscv_fwd_match #(
    .RF_ADDR_W  (RF_ADDR_W),
    .FWD_STAGES (FWD_STAGES),
    .IDX_W      (IDX_W)
  ) u_match_rs2 (
    .id_valid_i  (bus.id_valid),
    .rs_i        (bus.id_rs2),
    .rs_used_i   (bus.id_rs2_used),
    .ent_flags_i (flags_q),
    .ent_rd_i    (rd_q),
    .hit_o       (rs2_hit),
    .stage_o     (rs2_stage),
    .is_load_o   (rs2_load)
  );

  // Only the winning producer matters: an older load behind a younger ALU write is shadowed
  assign rs1_load_use = rs1_hit && rs1_load && (int'(rs1_stage) < LOAD_LAT);
  assign rs2_load_use = rs2_hit && rs2_load && (int'(rs2_stage) < LOAD_LAT);
  assign stall_id     = rs1_load_use || rs2_load_use;
  assign bus.stall_id = stall_id;

  always_comb begin
    bus.a_op_sel_fwd     = SEL_W'(bus.a_op_sel);
    bus.b_op_sel_fwd     = SEL_W'(bus.b_op_sel);
    bus.dmem_din_sel_fwd = '0;
    if (!stall_id) begin
      if (rs1_hit) begin
        bus.a_op_sel_fwd = SEL_W'(ALU_SEL_FWD_BASE + int'(rs1_stage));
      end
      if (rs2_hit) begin
        if (bus.id_store) begin
          bus.dmem_din_sel_fwd = SEL_W'(DMEM_DIN_FWD_BASE + int'(rs2_stage));
        end else begin
          bus.b_op_sel_fwd = SEL_W'(ALU_SEL_FWD_BASE + int'(rs2_stage));
        end
      end
    end
  end

  // A flushed or stalled ID instruction enters EX as a bubble
  assign insert = bus.id_valid && !bus.id_flush && !stall_id;

  always_comb begin
    flags_d = '0;
    rd_d    = '0;
    rd_d[0] = bus.id_rd;
    if (insert) begin
      flags_d[0].valid = 1'b1;
      flags_d[0].we    = bus.id_reg_we;
      flags_d[0].load  = bus.id_load;
    end
    for (int k = 1; k < FWD_STAGES; k++) begin
      flags_d[k] = flags_q[k-1];
      rd_d[k]    = rd_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      rd_q    <= '0;
    end else if (!bus.pipe_hold) begin
      flags_q <= flags_d;
      rd_q    <= rd_d;
    end
  end

`ifdef AMA_RISCV_HAZARD_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (stall_id && !bus.pipe_hold && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_ama_riscv_hazard_fwd_unit.sv
// tb/tb_ama_riscv_hazard_fwd_unit.sv - self-checking bench, default and 3-stage/LOAD_LAT=2 instances
module tb_ama_riscv_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_we, id_load, id_store;
  logic       a_op_sel, b_op_sel, pipe_hold, id_flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [31:0] perf0, perf1;

  ama_riscv_hazard_fwd_unit_if #(.RF_ADDR_W(5), .SEL_W(2)) bus0 ();
  ama_riscv_hazard_fwd_unit_if #(.RF_ADDR_W(5), .SEL_W(3)) bus1 ();

  assign bus0.id_valid = id_valid;       assign bus1.id_valid = id_valid;
  assign bus0.id_rs1 = id_rs1;           assign bus1.id_rs1 = id_rs1;
  assign bus0.id_rs2 = id_rs2;           assign bus1.id_rs2 = id_rs2;
  assign bus0.id_rs1_used = id_rs1_used; assign bus1.id_rs1_used = id_rs1_used;
  assign bus0.id_rs2_used = id_rs2_used; assign bus1.id_rs2_used = id_rs2_used;
  assign bus0.id_rd = id_rd;             assign bus1.id_rd = id_rd;
  assign bus0.id_reg_we = id_reg_we;     assign bus1.id_reg_we = id_reg_we;
  assign bus0.id_load = id_load;         assign bus1.id_load = id_load;
  assign bus0.id_store = id_store;       assign bus1.id_store = id_store;
  assign bus0.a_op_sel = a_op_sel;       assign bus1.a_op_sel = a_op_sel;
  assign bus0.b_op_sel = b_op_sel;       assign bus1.b_op_sel = b_op_sel;
  assign bus0.pipe_hold = pipe_hold;     assign bus1.pipe_hold = pipe_hold;
  assign bus0.id_flush = id_flush;       assign bus1.id_flush = id_flush;

  ama_riscv_hazard_fwd_unit #(.RF_ADDR_W(5), .FWD_STAGES(2), .LOAD_LAT(1)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
`ifdef AMA_RISCV_HAZARD_PERF_EN
    , .perf_stall_cnt (perf0)
`endif
  );

  ama_riscv_hazard_fwd_unit #(.RF_ADDR_W(5), .FWD_STAGES(3), .LOAD_LAT(2)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
`ifdef AMA_RISCV_HAZARD_PERF_EN
    , .perf_stall_cnt (perf1)
`endif
  );

`ifndef AMA_RISCV_HAZARD_PERF_EN
  assign perf0 = '0;
  assign perf1 = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per instance, a list of in-flight producers, index 0 = youngest (EX)
  int     m_v[2][4], m_rd[2][4], m_we[2][4], m_ld[2][4];
  int     m_n[2]   = '{2, 3};
  int     m_lat[2] = '{1, 2};
  longint m_perf[2];

  function automatic int m_win(input int i, input int rs, input logic used);
    if (!id_valid || !used || rs == 0) return -1;
    for (int k = 0; k < m_n[i]; k++)
      if (m_v[i][k] != 0 && m_we[i][k] != 0 && m_rd[i][k] == rs) return k;
    return -1;
  endfunction

  function automatic void m_eval(input int i, output int a, output int b, output int d, output int st);
    int k1, k2;
    k1 = m_win(i, int'(id_rs1), id_rs1_used);
    k2 = m_win(i, int'(id_rs2), id_rs2_used);
    st = ((k1 >= 0 && m_ld[i][k1] != 0 && k1 < m_lat[i]) ||
          (k2 >= 0 && m_ld[i][k2] != 0 && k2 < m_lat[i])) ? 1 : 0;
    a = (st == 0 && k1 >= 0) ? 2 + k1 : int'(a_op_sel);
    b = (st == 0 && !id_store && k2 >= 0) ? 2 + k2 : int'(b_op_sel);
    d = (st == 0 && id_store && k2 >= 0) ? 1 + k2 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_perf[i] = 0;
        for (int k = 0; k < 4; k++) m_v[i][k] = 0;
      end
    end else if (!pipe_hold) begin
      for (int i = 0; i < 2; i++) begin
        int a, b, d, st;
        m_eval(i, a, b, d, st);
        if (st != 0 && m_perf[i] != 64'hFFFF_FFFF) m_perf[i]++;
        for (int k = m_n[i] - 1; k > 0; k--) begin
          m_v[i][k] = m_v[i][k-1]; m_rd[i][k] = m_rd[i][k-1];
          m_we[i][k] = m_we[i][k-1]; m_ld[i][k] = m_ld[i][k-1];
        end
        m_v[i][0]  = (id_valid && !id_flush && st == 0) ? 1 : 0;
        m_rd[i][0] = int'(id_rd);
        m_we[i][0] = int'(id_reg_we);
        m_ld[i][0] = int'(id_load);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int a, b, d, st;
      m_eval(0, a, b, d, st);
      check("m0_a", 32'(bus0.a_op_sel_fwd), a);
      check("m0_b", 32'(bus0.b_op_sel_fwd), b);
      check("m0_d", 32'(bus0.dmem_din_sel_fwd), d);
      check("m0_stall", 32'(bus0.stall_id), st);
      m_eval(1, a, b, d, st);
      check("m1_a", 32'(bus1.a_op_sel_fwd), a);
      check("m1_b", 32'(bus1.b_op_sel_fwd), b);
      check("m1_d", 32'(bus1.dmem_din_sel_fwd), d);
      check("m1_stall", 32'(bus1.stall_id), st);
`ifdef AMA_RISCV_HAZARD_PERF_EN
      check("m0_perf", perf0, 32'(m_perf[0]));
      check("m1_perf", perf1, 32'(m_perf[1]));
`endif
    end
  end

  task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                        input int rd, input logic we, input logic ld, input logic st,
                        input logic asel, input logic bsel);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_reg_we = we; id_load = ld; id_store = st; a_op_sel = asel; b_op_sel = bsel;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; pipe_hold = 1'b0; id_flush = 1'b0;
    set_id(1'b1, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_a", 32'(bus0.a_op_sel_fwd), 1);
    check("rst_b", 32'(bus0.b_op_sel_fwd), 1);
    check("rst_d", 32'(bus0.dmem_din_sel_fwd), 0);
    check("rst_stall", 32'(bus0.stall_id), 0);
    step(); step();
    nop();
    rst_n = 1'b1;
    chk_en = 1'b1;

    set_id(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // addi x5,x1
    step();
    set_id(1'b1, 5, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // addi x5,x5
    settle();
    check("b2b_a", 32'(bus0.a_op_sel_fwd), 2);
    check("b2b_stall", 32'(bus0.stall_id), 0);
    step();
    set_id(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add x6,x5,x1
    settle();
    check("youngest_a", 32'(bus0.a_op_sel_fwd), 2);
    check("youngest_b", 32'(bus0.b_op_sel_fwd), 0);
    step();
    set_id(1'b1, 5, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);   // writes x0, reads x5 and x0
    settle();
    check("older_a", 32'(bus0.a_op_sel_fwd), 3);
    check("x0_src_b", 32'(bus0.b_op_sel_fwd), 1);
    step();
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);   // addi x9,x0 behind an x0 writer
    settle();
    check("x0_dst_a", 32'(bus0.a_op_sel_fwd), 1);
    check("x0_dst_b", 32'(bus0.b_op_sel_fwd), 0);
    step();
    set_id(1'b1, 9, 1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   // sw x9,0(x9)
    settle();
    check("st_a", 32'(bus0.a_op_sel_fwd), 2);
    check("st_d", 32'(bus0.dmem_din_sel_fwd), 1);
    check("st_b", 32'(bus0.b_op_sel_fwd), 1);
    check("st_d_3stage", 32'(bus1.dmem_din_sel_fwd), 1);
    step();

    set_id(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);   // lw x7
    step();
    set_id(1'b1, 0, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // add x8,x0,x7
    settle();
    check("lu_stall0", 32'(bus0.stall_id), 1);
    check("lu_pass_b0", 32'(bus0.b_op_sel_fwd), 0);
    check("lu_stall1", 32'(bus1.stall_id), 1);
    step();
    settle();
    check("lu_rel_stall0", 32'(bus0.stall_id), 0);
    check("lu_fwd_b0", 32'(bus0.b_op_sel_fwd), 3);
    check("lu_second_stall1", 32'(bus1.stall_id), 1);
    step();
    settle();
    check("lu_rel_stall1", 32'(bus1.stall_id), 0);
    check("lu_fwd_b1", 32'(bus1.b_op_sel_fwd), 4);
    step();

    set_id(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);   // lw x7, then held stall
    step();
    set_id(1'b1, 0, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("hold_pre_stall", 32'(bus0.stall_id), 1);
    pipe_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("hold_stall", 32'(bus0.stall_id), 1);
      check("hold_pass_b", 32'(bus0.b_op_sel_fwd), 0);
    end
    pipe_hold = 1'b0;
    step();
    settle();
    check("hold_rel_stall", 32'(bus0.stall_id), 0);
    check("hold_rel_b", 32'(bus0.b_op_sel_fwd), 3);
    step();

    set_id(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);   // lw x7, then flushed stall
    step();
    set_id(1'b1, 0, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("flush_pre_stall", 32'(bus0.stall_id), 1);
    id_flush = 1'b1;
    step();
    id_flush = 1'b0;
    set_id(1'b1, 8, 1'b1, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // reads x8 of the flushed op
    settle();
    check("flush_stall", 32'(bus0.stall_id), 0);
    check("flush_bubble_a", 32'(bus0.a_op_sel_fwd), 0);
    step();

    nop();
    step();
    set_id(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);   // lw x7, then reset mid-stall
    step();
    set_id(1'b1, 0, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    check("rst_pre_stall", 32'(bus0.stall_id), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_stall0", 32'(bus0.stall_id), 0);
    check("rst_mid_stall1", 32'(bus1.stall_id), 0);
    check("rst_mid_a", 32'(bus0.a_op_sel_fwd), 1);
    check("rst_mid_b", 32'(bus0.b_op_sel_fwd), 1);
    check("rst_mid_d", 32'(bus0.dmem_din_sel_fwd), 0);
`ifdef AMA_RISCV_HAZARD_PERF_EN
    check("rst_mid_perf", perf0, 0);
`endif
    step();
    nop();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 2, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      set_id(1'b1, 0, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
    end
    nop();
    settle();
`ifdef AMA_RISCV_HAZARD_PERF_EN
    check("perf_five", perf0, 5);
`endif
    check("perf_end_stall", 32'(bus0.stall_id), 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ama_riscv_hazard_fwd_unit.md
# ama_riscv_hazard_fwd_unit

Parametrised forwarding and hazard unit for the AMA-RISCV integer pipeline. It tracks destination-register state for up to `FWD_STAGES` stages downstream of decode and drives per-operand forward selects for ALU A, ALU B and store data, always choosing the youngest valid producer. It also detects load-use hazards and stalls ID until the loaded value reaches a forwardable stage. It sits beside the decode stage and drives the EX operand muxes and the ID/IF stall logic.

## Interface
Parameters:
- `RF_ADDR_W`, default 5: register address width.
- `FWD_STAGES`, default 2: number of tracked stages after ID. Stage 0 is EX. Legal range 1..4.
- `LOAD_LAT`, default 1: first stage index at which load data is forwardable. Legal range 0..`FWD_STAGES`-1; elaboration error outside it.
- `SEL_W`, derived, equals $clog2(`FWD_STAGES`+2): width of the forward select outputs.

Ports (clock and reset first):
- `clk`  in  1  the single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  `RF_ADDR_W`  source registers.
- `id_rs1_used`, `id_rs2_used`  in  1  the instruction reads that source.
- `id_rd`  in  `RF_ADDR_W`  destination register.
- `id_reg_we`  in  1  the instruction writes `id_rd`.
- `id_load`  in  1  the instruction is a load.
- `id_store`  in  1  the instruction is a store.
- `a_op_sel`, `b_op_sel`  in  1  decoder's non-forwarded operand selects.
- `pipe_hold`  in  1  external freeze (e.g. DMEM not ready). While high, all tracked state is held.
- `id_flush`  in  1  kill the ID instruction (branch or jump redirect).
- `a_op_sel_fwd`, `b_op_sel_fwd`  out  `SEL_W`  operand mux selects.
- `dmem_din_sel_fwd`  out  `SEL_W`  store-data select.
- `stall_id`  out  1  load-use stall request to IF and ID.

## Operation
- **Tracking state.** Array `ent[k]`, k = 0..`FWD_STAGES`-1, each entry holding {valid, rd, we, load}.
- **Advance rule.** When `pipe_hold`=0, on each rising edge:
  - `ent[k+1]` takes `ent[k]`.
  - `ent[0]` takes the ID instruction only if `id_valid` && !`id_flush` && !`stall_id`. Otherwise `ent[0]` takes a bubble (valid=0).
  - `id_flush` has priority over the ID insert.
  - The oldest entry is discarded.
- **Match condition.** Stage k matches source rs when `ent[k]`.valid && `ent[k]`.we && `ent[k]`.rd == rs && rs != 0 && rs_used && `id_valid`.
- **Priority.** The lowest k (youngest producer) wins.
- **Select encoding.**
  - 0 or 1: pass-through of the decoder select, zero-extended.
  - 2+k: forward from stage k.
  - For `dmem_din_sel_fwd`: 0 selects the RF value; 1+k forwards from stage k.
- **Operand routing.**
  - rs1 drives `a_op_sel_fwd` for every instruction type, including stores.
  - rs2 drives `b_op_sel_fwd` when !`id_store`.
  - When `id_store`=1, rs2 drives `dmem_din_sel_fwd` and `b_op_sel_fwd` is pass-through.
- **Load-use hazard.** `stall_id`=1 when the winning match for either used source is a load at stage k < `LOAD_LAT`.
  - While stalled, all selects are forced to pass-through.
  - Older, non-winning matches never cause a stall.
- **Hold.** `pipe_hold`=1 freezes the array. Outputs still evaluate combinationally against the frozen state.

## Timing
- All outputs are combinational from the ID inputs and the entry array. Zero-cycle latency.
- Entries update on the rising `clk` edge only.
- Load-use bubble count equals `LOAD_LAT`-k, where k is the load's stage when ID first sees it. With the defaults, a load immediately followed by a dependent instruction gives exactly 1 bubble, after which the dependent instruction forwards from stage 1.
- **Reset.** `rst_n` low clears every entry's valid bit immediately (asynchronously), including mid-stall. With all entries invalid:
  - `a_op_sel_fwd` = {0,`a_op_sel`}
  - `b_op_sel_fwd` = {0,`b_op_sel`}
  - `dmem_din_sel_fwd` = 0
  - `stall_id` = 0
  - the performance counter = 0
- `id_flush` together with `stall_id` inserts a bubble; the stall releases on the next cycle because the ID instruction is gone.
- `pipe_hold` together with `stall_id` holds the array; `stall_id` stays asserted.

## Configuration
- `AMA_RISCV_HAZARD_PERF_EN` defined:
  - Adds output port `perf_stall_cnt` (out, 32).
  - Increments by 1 on each edge where `stall_id`=1 and `pipe_hold`=0.
  - Saturates at 32'hFFFF_FFFF.
  - Reset value 0.
- Macro undefined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared defines/package holds:
  - `RF_X0_ZERO`
  - the select encodings: `ALU_SEL_FWD_BASE`=2, `DMEM_DIN_FWD_BASE`=1
  - the entry struct field widths
- One sub-module, `ama_riscv_fwd_match`: a combinational per-source priority matcher. It outputs hit, stage index and is_load, and is instantiated twice (rs1, rs2).

## Test plan
- **Back-to-back ALU dependency.** `addi x5` then `add x6,x5,x1` → `a_op_sel_fwd`=2, `stall_id`=0.
- **Two producers of the same register.** x5 written at stage 0 and stage 1, `FWD_STAGES`=2 → stage 0 wins, select=2. With only stage 1 valid → select=3.
- **Load-use with defaults.** `lw x7` then `add x8,x0,x7` → `stall_id`=1 for exactly 1 cycle, `ent[0]` becomes a bubble, then `b_op_sel_fwd`=3. Repeat with `LOAD_LAT`=2, `FWD_STAGES`=3 → 2 stall cycles.
- **Store data and x0 rules.** `sw x9,0(x9)` with x9 at stage 0 → `a_op_sel_fwd`=2, `dmem_din_sel_fwd`=1, `b_op_sel_fwd`={0,`b_op_sel`}. Any access to x0 → no forward.
- **Hold and flush.** `pipe_hold`=1 for 3 cycles during a load-use stall → the array is frozen and `stall_id` stays 1. `id_flush` during the stall → bubble inserted, `stall_id`=0 next cycle.
- **Reset and performance counter.** `rst_n` asserted mid-stall → all outputs take their reset values immediately. With `AMA_RISCV_HAZARD_PERF_EN`, 5 stall cycles → `perf_stall_cnt`=5.
